// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory, and registers each word into a valid/ready stage for decode.
// Optional halt-on-self-jump detection is enabled by defining FETCH_HALT_DETECT_EN.
//
//   state | meaning
//   IDLE  | not fetching; the PC can still be redirected
//   FETCH | one fetch per cycle while run is high and the output stage can take a word
//   HALT  | a self-jump was issued; no fetches until a redirect or reset
module instr_fetch_ctrl #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              fetch_slot;
  logic              halt_hit;

  assign imem_addr  = pc;
  assign accept     = out_valid && out_ready;
  assign fetch_slot = (state == FETCH) && run && (!out_valid || out_ready) && !redirect_valid;
  assign busy       = (state == FETCH);

`ifdef FETCH_HALT_DETECT_EN
  // A jump whose target equals its own address spins forever; stop fetching instead.
  assign halt_hit = (imem_instr[31:26] == 6'b010100) && (imem_instr[ADDR_W-1:0] == pc);
  assign halted   = (state == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else begin
      if (accept)
        fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        // Redirect beats fetch; an accepted word is still counted above before the flush.
        pc        <= redirect_pc;
        out_valid <= 1'b0;
        case (state)
          IDLE:    state <= IDLE;
          default: state <= run ? FETCH : IDLE;
        endcase
      end else begin
        case (state)
          IDLE:    if (run) state <= FETCH;
          FETCH:   if (!run) state <= IDLE;
          default: state <= HALT;
        endcase

        if (fetch_slot) begin
          out_instr <= imem_instr;
          out_pc    <= pc;
          out_valid <= 1'b1;
          pc        <= pc + ADDR_W'(1);
          if (halt_hit)
            state <= HALT;
        end else if (accept) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
